// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared canvas frame-buffer constants, color codes and clear FSM states
package fb_pkg;
  localparam int CANVAS_H      = 640;
  localparam int CANVAS_V      = 360;
  localparam int COLOR_WIDTH   = 4;
  localparam int FB_DEPTH      = CANVAS_H * CANVAS_V;
  localparam int FB_ADDR_WIDTH = $clog2(FB_DEPTH);

  typedef enum logic [COLOR_WIDTH-1:0] {
    BLACK   = 4'd0,
    WHITE   = 4'd1,
    RED     = 4'd2,
    GREEN   = 4'd3,
    BLUE    = 4'd4,
    CYAN    = 4'd5,
    MAGENTA = 4'd6,
    YELLOW  = 4'd7,
    GRAY    = 4'd8
  } fb_color_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CLEAR,
    DONE
  } fb_clr_state_t;
endpackage

// File: rtl/fb_clear_arbiter_if.sv
// rtl/fb_clear_arbiter_if.sv - requester and frame-buffer port A signals of the clear arbiter
interface fb_clear_arbiter_if #(
  parameter int ADDR_WIDTH  = fb_pkg::FB_ADDR_WIDTH,
  parameter int COLOR_WIDTH = fb_pkg::COLOR_WIDTH
);
  logic                   clear_req_in;
  logic [COLOR_WIDTH-1:0] clear_color_in;
  logic                   sync_to_frame_in;
  logic                   nf_in;
  logic                   brush_we_in;
  logic [ADDR_WIDTH-1:0]  brush_addr_in;
  logic [COLOR_WIDTH-1:0] brush_color_in;
  logic                   wr_en_out;
  logic [ADDR_WIDTH-1:0]  wr_addr_out;
  logic [COLOR_WIDTH-1:0] wr_data_out;
  logic                   busy_out;
  logic                   done_out;
  logic [15:0]            drop_count_out;

  modport slave (
    input  clear_req_in, clear_color_in, sync_to_frame_in, nf_in,
    input  brush_we_in, brush_addr_in, brush_color_in,
    output wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, drop_count_out
  );

  modport master (
    output clear_req_in, clear_color_in, sync_to_frame_in, nf_in,
    output brush_we_in, brush_addr_in, brush_color_in,
    input  wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, drop_count_out
  );
endinterface

// File: rtl/fb_sweep_counter.sv
// rtl/fb_sweep_counter.sv - loadable sweep address counter flagging the last buffer address
module fb_sweep_counter #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  terminal
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + ADDR_WIDTH'(1);
    end
  end

  assign terminal = (count == ADDR_WIDTH'(DEPTH - 1));
endmodule

// File: rtl/fb_clear_arbiter.sv
// rtl/fb_clear_arbiter.sv - frame-buffer port A owner: brush pass-through vs full-canvas clear sweep
module fb_clear_arbiter #(
  parameter int H_PIXELS    = fb_pkg::CANVAS_H,
  parameter int V_PIXELS    = fb_pkg::CANVAS_V,
  parameter int COLOR_WIDTH = fb_pkg::COLOR_WIDTH,
  localparam int DEPTH      = H_PIXELS * V_PIXELS,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  fb_clear_arbiter_if.slave bus
);
  import fb_pkg::*;

  logic [1:0]             rst_pipe;
  logic                   rst_n;
  fb_clr_state_t          state, next_state;
  logic [COLOR_WIDTH-1:0] color_q;
  logic [ADDR_WIDTH-1:0]  cnt, cnt_load_value, clr_addr;
  logic [COLOR_WIDTH-1:0] clr_data;
  logic                   cnt_load, cnt_en, cnt_tc;
  logic                   fwd, clr_emit, drop;

  // Reset asserts asynchronously but releases two edges later, clean of the clock.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_pipe <= 2'b00;
    else           rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  fb_sweep_counter #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_sweep (
    .clk(pixel_clk_in), .rst_n(rst_n), .load(cnt_load), .load_value(cnt_load_value),
    .en(cnt_en), .count(cnt), .terminal(cnt_tc)
  );

  // The edge that starts the sweep already emits address 0 unless a brush write claims the port.
  always_comb begin
    next_state     = state;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    fwd            = 1'b0;
    clr_emit       = 1'b0;
    clr_addr       = cnt;
    clr_data       = color_q;
    drop           = 1'b0;
    case (state)
      IDLE: begin
        fwd = bus.brush_we_in;
        if (bus.clear_req_in) begin
          cnt_load = 1'b1;
          if (bus.sync_to_frame_in) begin
            next_state = WAIT_FRAME;
          end else begin
            next_state = CLEAR;
            if (!bus.brush_we_in) begin
              clr_emit       = 1'b1;
              clr_addr       = '0;
              clr_data       = bus.clear_color_in;
              cnt_load_value = ADDR_WIDTH'(1);
            end
          end
        end
      end
      WAIT_FRAME: begin
        fwd = bus.brush_we_in;
        if (bus.nf_in) begin
          next_state = CLEAR;
          if (!bus.brush_we_in) begin
            clr_emit = 1'b1;
            cnt_en   = 1'b1;
          end
        end
      end
      CLEAR: begin
        clr_emit = 1'b1;
        drop     = bus.brush_we_in;
        if (cnt_tc) next_state = DONE;
        else        cnt_en     = 1'b1;
      end
      DONE: begin
        fwd        = bus.brush_we_in;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      color_q            <= '0;
      bus.wr_en_out      <= 1'b0;
      bus.wr_addr_out    <= '0;
      bus.wr_data_out    <= '0;
      bus.busy_out       <= 1'b0;
      bus.done_out       <= 1'b0;
      bus.drop_count_out <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.clear_req_in) color_q <= bus.clear_color_in;
      bus.wr_en_out <= fwd | clr_emit;
      if (clr_emit) begin
        bus.wr_addr_out <= clr_addr;
        bus.wr_data_out <= clr_data;
      end else if (fwd) begin
        bus.wr_addr_out <= bus.brush_addr_in;
        bus.wr_data_out <= bus.brush_color_in;
      end
      bus.busy_out <= (next_state != IDLE);
      bus.done_out <= (state == DONE);
      if (drop && bus.drop_count_out != 16'hFFFF)
        bus.drop_count_out <= bus.drop_count_out + 16'd1;
    end
  end
endmodule

// File: tb/tb_fb_clear_arbiter.sv
// tb/tb_fb_clear_arbiter.sv - self-checking bench for fb_clear_arbiter against a behavioural model
module tb_fb_clear_arbiter;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fb_clear_arbiter_if #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW)) bus ();
  fb_clear_arbiter_if #(.ADDR_WIDTH(18), .COLOR_WIDTH(4))  big ();

  fb_clear_arbiter #(.H_PIXELS(8), .V_PIXELS(2), .COLOR_WIDTH(CW)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .bus(bus.slave)
  );
  fb_clear_arbiter big_dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .bus(big.slave)
  );

  int checks = 0;
  int errors = 0;
  int ph, nxt, mcol, rst_hold;
  int e_en, e_addr, e_data, e_busy, e_done, e_drop;

  // Model: ph 0 idle, 1 waiting for frame, 2 sweeping, 3 finishing; nxt is the next address to clear.
  task automatic model_reset();
    ph = 0; nxt = 0; mcol = 0;
    e_en = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0; e_drop = 0;
  endtask

  task automatic emit();
    e_en = 1; e_addr = nxt; e_data = mcol;
    nxt = nxt + 1;
    if (nxt == DEPTH) ph = 3;
  endtask

  task automatic forward();
    if (bus.brush_we_in) begin
      e_en = 1; e_addr = int'(bus.brush_addr_in); e_data = int'(bus.brush_color_in);
    end
  endtask

  task automatic model_edge();
    e_en = 0; e_done = 0;
    case (ph)
      0: begin
        forward();
        if (bus.clear_req_in) begin
          mcol = int'(bus.clear_color_in); nxt = 0;
          if (bus.sync_to_frame_in) ph = 1;
          else begin
            ph = 2;
            if (!bus.brush_we_in) emit();
          end
        end
      end
      1: begin
        forward();
        if (bus.nf_in) begin
          ph = 2;
          if (!bus.brush_we_in) emit();
        end
      end
      2: begin
        if (bus.brush_we_in && e_drop < 65535) e_drop = e_drop + 1;
        emit();
      end
      default: begin
        forward(); e_done = 1; ph = 0;
      end
    endcase
    e_busy = (ph != 0) ? 1 : 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("wr_en",  32'(bus.wr_en_out),      32'(e_en));
    check("wr_addr", 32'(bus.wr_addr_out),   32'(e_addr));
    check("wr_data", 32'(bus.wr_data_out),   32'(e_data));
    check("busy",   32'(bus.busy_out),       32'(e_busy));
    check("done",   32'(bus.done_out),       32'(e_done));
    check("drops",  32'(bus.drop_count_out), 32'(e_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || rst_hold > 0) begin
      model_reset();
      if (rst_n) rst_hold--;
    end else begin
      model_edge();
    end
    #1 compare_all();
  endtask

  task automatic idle();
    bus.clear_req_in = 1'b0; bus.clear_color_in = '0; bus.sync_to_frame_in = 1'b0;
    bus.nf_in = 1'b0; bus.brush_we_in = 1'b0; bus.brush_addr_in = '0; bus.brush_color_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    repeat (2) tick();
    rst_n = 1'b1; rst_hold = 2;
    repeat (3) tick();
  endtask

  initial begin
    rst_hold = 0;
    model_reset();
    idle();
    big.clear_req_in = 1'b0; big.clear_color_in = '0; big.sync_to_frame_in = 1'b0;
    big.nf_in = 1'b0; big.brush_we_in = 1'b0; big.brush_addr_in = '0; big.brush_color_in = '0;
    #2 do_reset();

    // Reset in the middle of a sweep, then a single brush write.
    bus.clear_req_in = 1'b1; bus.clear_color_in = 4'd9; tick();
    idle(); repeat (3) tick();
    do_reset();
    check("rst_wr_en", 32'(bus.wr_en_out), 32'd0);
    bus.brush_we_in = 1'b1; bus.brush_addr_in = 4'd5; bus.brush_color_in = 4'd3; tick();
    check("brush_en", 32'(bus.wr_en_out), 32'd1);
    check("brush_addr", 32'(bus.wr_addr_out), 32'd5);
    check("brush_data", 32'(bus.wr_data_out), 32'd3);
    idle(); tick();

    // Unsynchronised clear in red with an ignored re-request mid-sweep.
    bus.clear_req_in = 1'b1; bus.clear_color_in = 4'd2; tick();
    check("clr_first_addr", 32'(bus.wr_addr_out), 32'd0);
    check("clr_first_busy", 32'(bus.busy_out), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (k == 8) bus.clear_req_in = 1'b1;
      tick();
      if (k == 15) check("clr_last_addr", 32'(bus.wr_addr_out), 32'd15);
      if (k == 15) check("clr_last_busy", 32'(bus.busy_out), 32'd1);
      if (k == 16) check("clr_done", 32'(bus.done_out), 32'd1);
      if (k == 16) check("clr_done_busy", 32'(bus.busy_out), 32'd0);
    end

    // Brush writes during the sweep are dropped and counted.
    do_reset();
    bus.clear_req_in = 1'b1; bus.clear_color_in = 4'd4; tick();
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (k >= 3 && k <= 7) begin
        bus.brush_we_in = 1'b1; bus.brush_addr_in = AW'($urandom); bus.brush_color_in = CW'($urandom);
      end
      tick();
    end
    check("drop_five", 32'(bus.drop_count_out), 32'd5);

    // Frame-synchronised clear with a brush write forwarded while waiting.
    bus.clear_req_in = 1'b1; bus.sync_to_frame_in = 1'b1; bus.clear_color_in = 4'd6; tick();
    for (int k = 1; k <= 30; k++) begin
      idle();
      if (k == 4) begin
        bus.brush_we_in = 1'b1; bus.brush_addr_in = 4'd12; bus.brush_color_in = 4'd1;
      end
      if (k == 10) bus.nf_in = 1'b1;
      tick();
      if (k == 4) check("wait_brush_addr", 32'(bus.wr_addr_out), 32'd12);
      if (k == 9) check("wait_no_write", 32'(bus.wr_en_out), 32'd0);
      if (k == 9) check("wait_busy", 32'(bus.busy_out), 32'd1);
      if (k == 10) check("sync_first_addr", 32'(bus.wr_addr_out), 32'd0);
      if (k == 10) check("sync_first_data", 32'(bus.wr_data_out), 32'd6);
    end

    // Clear request and brush write on the same idle edge.
    bus.clear_req_in = 1'b1; bus.clear_color_in = 4'd5;
    bus.brush_we_in = 1'b1; bus.brush_addr_in = 4'd9; bus.brush_color_in = 4'd7; tick();
    check("same_brush_addr", 32'(bus.wr_addr_out), 32'd9);
    check("same_brush_data", 32'(bus.wr_data_out), 32'd7);
    idle(); tick();
    check("same_clr_addr", 32'(bus.wr_addr_out), 32'd0);
    check("same_clr_data", 32'(bus.wr_data_out), 32'd5);
    repeat (20) tick();

    // Asynchronous reset while the sweep is at address 6.
    bus.clear_req_in = 1'b1; bus.clear_color_in = 4'd3; tick();
    idle();
    repeat (6) tick();
    check("pre_rst_addr", 32'(bus.wr_addr_out), 32'd6);
    do_reset();
    check("post_rst_busy", 32'(bus.busy_out), 32'd0);
    bus.clear_req_in = 1'b1; bus.clear_color_in = 4'd8; tick();
    check("restart_addr", 32'(bus.wr_addr_out), 32'd0);
    check("restart_en", 32'(bus.wr_en_out), 32'd1);
    idle(); repeat (20) tick();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus.clear_req_in     = ($urandom_range(0, 19) == 0);
      bus.clear_color_in   = CW'($urandom);
      bus.sync_to_frame_in = $urandom_range(0, 1) == 1;
      bus.nf_in            = ($urandom_range(0, 7) == 0);
      bus.brush_we_in      = $urandom_range(0, 1) == 1;
      bus.brush_addr_in    = AW'($urandom);
      bus.brush_color_in   = CW'($urandom);
      tick();
    end
    idle();

    // Drop counter saturation on a full-size canvas.
    big.clear_req_in = 1'b1; tick();
    big.clear_req_in = 1'b0; big.brush_we_in = 1'b1;
    repeat (1000) tick();
    check("big_drop_1000", 32'(big.drop_count_out), 32'd1000);
    repeat (69000) tick();
    check("big_drop_sat", 32'(big.drop_count_out), 32'h0000FFFF);
    check("big_busy", 32'(big.busy_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
